// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources, timing each frame plus gap itself.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [7:0]                 tx_byte,
  output logic                       tx_start,
  output logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  // state | meaning
  // IDLE  | no frame in flight; arbitrate on any req
  // SEND  | single cycle carrying tx_start and ack
  // HOLD  | frame plus gap draining on the counter; req ignored
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(FRAME_CYCLES + GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [IW-1:0] sel;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) sel = IW'(i);
    end
  end
`else
  logic [IW-1:0] last_grant;
  logic [IW-1:0] idx;
  logic          found;

  // Scan starts just after the previous winner so it becomes lowest priority.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      ack      <= '0;
      tx_byte  <= '0;
      tx_start <= 1'b0;
      tx_busy  <= 1'b0;
      grant_id <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant <= IW'(NUM_REQ - 1);
`endif
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            tx_byte  <= data[{sel, 3'b000} +: 8];
            grant_id <= sel;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= sel;
`endif
            ack      <= NUM_REQ'(1) << sel;
            tx_start <= 1'b1;
            tx_busy  <= 1'b1;
            counter  <= LOAD;
            state    <= SEND;
          end
        end
        SEND, HOLD: begin
          if (counter == '0) begin
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter - 1'b1;
            state   <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: default instance plus a 2-requester, 1-cycle-frame, no-gap instance.
// A busy-cycles-remaining model predicts every output each cycle; directed tests pin grant order and timing.
module tb_uart_tx_arbiter;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] data  = '0;
  logic [3:0]  ack;
  logic [7:0]  tx_byte;
  logic        tx_start, tx_busy;
  logic [1:0]  grant_id;

  logic [1:0]  req2  = '0;
  logic [15:0] data2 = '0;
  logic [1:0]  ack2;
  logic [7:0]  tx_byte2;
  logic        tx_start2, tx_busy2;
  logic [0:0]  grant_id2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n;

  always #5 clock = ~clock;

  uart_tx_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .ack(ack),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .FRAME_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clock(clock), .reset(reset), .req(req2), .data(data2), .ack(ack2),
    .tx_byte(tx_byte2), .tx_start(tx_start2), .tx_busy(tx_busy2), .grant_id(grant_id2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_rem counts busy cycles still owed; a grant is possible only when none are owed.
  int         m_rem[2], m_last[2], m_id[2];
  logic [7:0] m_ack[2], m_byte[2];
  logic       m_start[2], m_busy[2];
  bit         m_valid = 1'b0;

  task automatic mstep(input int d, input logic [7:0] r, input logic [63:0] dat,
                       input int nreq, input int blen);
    int sel;
    sel = -1;
    if (reset) begin
      m_rem[d] = 0; m_last[d] = nreq - 1; m_id[d] = 0;
      m_ack[d] = '0; m_byte[d] = '0; m_start[d] = 1'b0; m_busy[d] = 1'b0;
    end else if (m_rem[d] == 0 && r != 0) begin
      if (FIXED) begin
        for (int i = 0; i < nreq; i++) if (sel < 0 && r[i]) sel = i;
      end else begin
        for (int i = 1; i <= nreq; i++)
          if (sel < 0 && r[(m_last[d] + i) % nreq]) sel = (m_last[d] + i) % nreq;
      end
      m_rem[d] = blen; m_busy[d] = 1'b1; m_start[d] = 1'b1;
      m_ack[d] = 8'(1 << sel); m_byte[d] = dat[sel*8 +: 8];
      m_id[d] = sel; m_last[d] = sel;
    end else begin
      m_start[d] = 1'b0; m_ack[d] = '0;
      if (m_rem[d] > 0) m_rem[d]--;
      m_busy[d] = (m_rem[d] > 0);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset) m_valid = 1'b1;
    mstep(0, {4'b0, req}, {32'b0, data}, 4, 12);
    mstep(1, {6'b0, req2}, {48'b0, data2}, 2, 1);
  end

  int g_id[$], g_cyc[$], g2_id[$], g2_cyc[$];
  bit pb0 = 1'b0, pb1 = 1'b0;

  always @(negedge clock) begin
    if (m_valid) begin
      chk("ack", ack, m_ack[0]);
      chk("tx_byte", tx_byte, m_byte[0]);
      chk("tx_start", tx_start, m_start[0]);
      chk("tx_busy", tx_busy, m_busy[0]);
      chk("grant_id", grant_id, m_id[0]);
      chk("ack_onehot", $onehot0(ack), 1);
      chk("ack2", ack2, m_ack[1]);
      chk("tx_byte2", tx_byte2, m_byte[1]);
      chk("tx_start2", tx_start2, m_start[1]);
      chk("tx_busy2", tx_busy2, m_busy[1]);
      chk("grant_id2", grant_id2, m_id[1]);
      if (tx_start) begin
        chk("start_after_busy", pb0, 0);
        g_id.push_back(int'(grant_id)); g_cyc.push_back(cyc);
      end
      if (tx_start2) begin
        chk("start_after_busy2", pb1, 0);
        g2_id.push_back(int'(grant_id2)); g2_cyc.push_back(cyc);
      end
      pb0 = tx_busy;
      pb1 = tx_busy2;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    req = '0; req2 = '0;
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    g_id.delete(); g_cyc.delete(); g2_id.delete(); g2_cyc.delete();
  endtask

  initial begin
    do_reset();

    // single requester
    data = 32'h0041_0000; req = 4'b0100; tick();
    chk("t1_start", tx_start, 1);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_byte", tx_byte, 8'h41);
    chk("t1_id", grant_id, 2);
    req = '0;
    n = 0;
    while (tx_busy && n < 40) begin n++; tick(); end
    chk("t1_busy_len", n, 12);

    // all four continuously
    do_reset();
    data = 32'h1312_1110; req = 4'b1111;
    for (int i = 0; i < 100 && g_id.size() < 5; i++) tick();
    req = '0;
    chk("t2_count", g_id.size(), 5);
    for (int i = 0; i < g_id.size() && i < 5; i++) begin
      chk("t2_order", g_id[i], FIXED ? 0 : i % 4);
      if (i > 0) chk("t2_period", g_cyc[i] - g_cyc[i-1], 13);
    end

    // late request while busy
    do_reset();
    data = 32'h3322_1100; req = 4'b0001;
    for (int i = 0; i < 50 && g_id.size() < 1; i++) tick();
    req = '0;
    for (int i = 0; i < 50 && tx_busy; i++) tick();
    req = 4'b0011;
    for (int i = 0; i < 50 && g_id.size() < 2; i++) tick();
    req = 4'b0001;
    tick(); tick(); tick();
    req = 4'b1001;
    for (int i = 0; i < 50 && g_id.size() < 3; i++) tick();
    req = '0;
    chk("t3_count", g_id.size(), 3);
    if (g_id.size() == 3) begin
      chk("t3_second", g_id[1], FIXED ? 0 : 1);
      chk("t3_late", g_id[2], FIXED ? 0 : 3);
      chk("t3_gap", g_cyc[2] - g_cyc[1], 13);
    end

    // reset mid-frame
    do_reset();
    data = 32'h3322_1100; req = 4'b0100;
    for (int i = 0; i < 50 && g_id.size() < 1; i++) tick();
    req = '0;
    tick(); tick(); tick(); tick(); tick();
    reset = 1'b1; tick();
    chk("t4_ack", ack, 0);
    chk("t4_byte", tx_byte, 0);
    chk("t4_start", tx_start, 0);
    chk("t4_busy", tx_busy, 0);
    chk("t4_id", grant_id, 0);
    g_id.delete(); g_cyc.delete();
    reset = 1'b0; req = 4'b1111;
    for (int i = 0; i < 50 && g_id.size() < 1; i++) tick();
    req = '0;
    chk("t4_count", g_id.size(), 1);
    if (g_id.size() == 1) chk("t4_first", g_id[0], 0);

    // short frame, no gap, two requesters
    do_reset();
    data2 = 16'hB1B0; req2 = 2'b11;
    for (int i = 0; i < 30 && g2_id.size() < 4; i++) tick();
    req2 = '0;
    chk("t5_count", g2_id.size(), 4);
    for (int i = 0; i < g2_id.size() && i < 4; i++) begin
      chk("t5_order", g2_id[i], FIXED ? 0 : i % 2);
      if (i > 0) chk("t5_period", g2_cyc[i] - g2_cyc[i-1], 2);
    end

    // two sparse requesters held
    do_reset();
    data = 32'hD3C2_B1A0; req = 4'b1010;
    for (int i = 0; i < 100 && g_id.size() < 3; i++) tick();
    req = '0;
    chk("t6_count", g_id.size(), 3);
    for (int i = 0; i < g_id.size() && i < 3; i++)
      chk("t6_grant", g_id[i], (FIXED || i != 1) ? 1 : 3);
    for (int i = 0; i < 50 && tx_busy; i++) tick();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
